// File: rtl/nor_vector_checker.sv
// Stimulus/checker stage for a 2-input NOR gate: walks the truth table,
// settles, compares y. Optional macro NOR_CHK_X_VECTORS_EN adds x vectors.
module nor_vector_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int LATW          = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            start,
  output logic            a,
  output logic            b,
  input  logic            y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [3:0]      err_count,
  output logic [2:0]      vec_idx,
  output logic [LATW-1:0] latency
);

`ifdef NOR_CHK_X_VECTORS_EN
  localparam int NVEC = 8;
`else
  localparam int NVEC = 4;
`endif

  localparam logic [2:0]      LAST_VEC = 3'(NVEC - 1);
  localparam logic [LATW-1:0] SETTLE_L = LATW'(SETTLE_CYCLES);
  localparam logic [LATW-1:0] WAIT_END = LATW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic logic [1:0] vec_ab(input logic [2:0] i);
    case (i)
      3'd0:    vec_ab = 2'b00;
      3'd1:    vec_ab = 2'b01;
      3'd2:    vec_ab = 2'b10;
      3'd3:    vec_ab = 2'b11;
`ifdef NOR_CHK_X_VECTORS_EN
      3'd4:    vec_ab = 2'b0x;
      3'd5:    vec_ab = 2'bx0;
      3'd6:    vec_ab = 2'b1x;
      3'd7:    vec_ab = 2'bx1;
`endif
      default: vec_ab = 2'b00;
    endcase
  endfunction

  function automatic logic vec_exp(input logic [2:0] i);
    case (i)
      3'd0:    vec_exp = 1'b1;
`ifdef NOR_CHK_X_VECTORS_EN
      3'd4:    vec_exp = 1'bx;
      3'd5:    vec_exp = 1'bx;
`endif
      default: vec_exp = 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic            a_q, a_d, b_q, b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [3:0]      err_q, err_d;
  logic [2:0]      vec_q, vec_d;
  logic [LATW-1:0] lat_q, lat_d;
  logic [LATW-1:0] wcnt_q, wcnt_d;
  logic [LATW-1:0] lat_tmp_q, lat_tmp_d;
  logic            lat_seen_q, lat_seen_d;

  logic            exp_y;
  logic            match;
  logic            last;
  logic [2:0]      vec_nxt;
  logic [1:0]      ab_nxt;
  logic [1:0]      ab_first;

  // x on y must never count as a match, hence case equality
  always_comb begin
    exp_y    = vec_exp(vec_q);
    match    = (y === exp_y);
    last     = (vec_q == LAST_VEC);
    vec_nxt  = vec_q + 3'd1;
    ab_nxt   = vec_ab(vec_nxt);
    ab_first = vec_ab(3'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q    <= S_IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      vec_q      <= '0;
      lat_q      <= '0;
      wcnt_q     <= '0;
      lat_tmp_q  <= '0;
      lat_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      lat_q      <= lat_d;
      wcnt_q     <= wcnt_d;
      lat_tmp_q  <= lat_tmp_d;
      lat_seen_q <= lat_seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_DONE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (wcnt_q == WAIT_END) state_d = S_CHECK;
      S_CHECK: state_d = last ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    vec_d      = vec_q;
    lat_d      = lat_q;
    wcnt_d     = wcnt_q;
    lat_tmp_d  = lat_tmp_q;
    lat_seen_d = lat_seen_q;
    unique case (state_q)
      S_IDLE,
      S_DONE: begin
        if (start) begin
          vec_d      = '0;
          {a_d, b_d} = ab_first;
          wcnt_d     = '0;
          lat_seen_d = 1'b0;
          err_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + LATW'(1);
        // latency counts clocks since apply, so first sample is 1
        if (!lat_seen_q && match) begin
          lat_tmp_d  = wcnt_q + LATW'(1);
          lat_seen_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (!match && err_q != 4'hF) err_d = err_q + 4'd1;
        lat_d = lat_seen_q ? lat_tmp_q : SETTLE_L;
        if (last) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == 4'd0);
        end else begin
          vec_d      = vec_nxt;
          {a_d, b_d} = ab_nxt;
          wcnt_d     = '0;
          lat_seen_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_q;
  assign latency   = lat_q;

endmodule

// File: tb/tb_nor_vector_checker.sv
// Scoreboard bench for nor_vector_checker: directed gate models,
// expected run results queued at start, checked when done rises.
module tb_nor_vector_checker;

`ifdef NOR_CHK_X_VECTORS_EN
  localparam int NV = 8;
`else
  localparam int NV = 4;
`endif
  localparam int SETTLE = 4;
  localparam int RUNLEN = NV * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       start = 1'b0;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] vec_idx;
  logic [3:0] latency;
  int         mode = 0;

  typedef struct {
    int err;
    int pas;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  nor_vector_checker #(.SETTLE_CYCLES(SETTLE), .LATW(4)) dut (
    .clk(clk), .reset_L(reset_L), .start(start),
    .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_idx(vec_idx), .latency(latency)
  );

  always #5 clk = ~clk;

  // gate models: 0 ideal NOR, 1 tied 0, 2 OR gate, 3 tied 1
  always_comb begin
    y = ~(a | b);
    case (mode)
      1: y = 1'b0;
      2: y = a | b;
      3: y = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("err_count", int'(err_count), e.err);
        check("pass", int'(pass), e.pas);
        check("latency", int'(latency), e.lat);
      end
    end
    done_prev = done;
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_a"}, int'(a), 0);
    check({tag, "_b"}, int'(b), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_vec"}, int'(vec_idx), 0);
    check({tag, "_lat"}, int'(latency), 0);
  endtask

  task automatic run(input int m, input int e_err, input int e_lat,
                     input int glitch);
    int n;
    exp_t e;
    @(negedge clk);
    mode = m;
    e.err = e_err;
    e.pas = (e_err == 0) ? 1 : 0;
    e.lat = e_lat;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("done_after_start", int'(done), 0);
    n = 0;
    while (!done && n < 4 * RUNLEN) begin
      start = (n == glitch - 1);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("run_cycles", n, RUNLEN);
    check("busy_at_done", int'(busy), 0);
    check("vec_idx_at_done", int'(vec_idx), NV - 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_held", int'(done), 1);
    check("err_held", int'(err_count), e_err);
  endtask

  initial begin
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_busy", int'(busy), 0);

`ifdef NOR_CHK_X_VECTORS_EN
    run(0, 0, 1, -10);
    run(1, 3, 1, -10);
    run(3, 7, 4, -10);
    run(0, 0, 1, 7);
`else
    run(0, 0, 1, -10);
    run(1, 1, 1, -10);
    run(2, 4, 4, -10);
    run(3, 3, 4, -10);
    run(0, 0, 1, 7);
`endif

    // reset in the middle of a run
    @(negedge clk);
    mode = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("midrun_reset");
    @(negedge clk);
    reset_L = 1'b1;
    repeat (RUNLEN + 2) @(posedge clk);
    #1;
    check("idle_after_reset", int'(done), 0);

    run(0, 0, 1, -10);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
